// File: rtl/display_scan_pkg.sv
// Shared definitions for the display scan capture block: glyph patterns,
// the invalid code, the FSM state type and enable-pattern helpers.
package display_scan_pkg;

    // Active-high {g,f,e,d,c,b,a} patterns, one per displayable code.
    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_WATER = 7'h1C;
    localparam logic [6:0] GLYPH_DASH  = 7'h40;
    localparam logic [6:0] GLYPH_ERROR = 7'h79;

    localparam logic [3:0] GLYPH_INVALID = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SETTLING,
        HOLD,
        MULTI
    } scan_state_t;

    typedef enum logic [1:0] {
        EN_NONE,
        EN_SINGLE,
        EN_MULTI
    } enable_class_t;

    function automatic enable_class_t classify_enables(input logic [3:0] enables_n);
        int unsigned active;
        active = 0;
        for (int i = 0; i < 4; i++) begin
            if (!enables_n[i]) begin
                active = active + 1;
            end
        end
        if (active == 0) begin
            return EN_NONE;
        end else if (active == 1) begin
            return EN_SINGLE;
        end
        return EN_MULTI;
    endfunction

    // Index of the lowest active (low) enable; only meaningful for EN_SINGLE.
    function automatic logic [1:0] active_index(input logic [3:0] enables_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!enables_n[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/display_scan_capture_decoder.sv
// Reverse glyph lookup: maps an active-high segment pattern back to its
// 4-bit code, flagging patterns that no code produces.
module segment_glyph_decoder
    import display_scan_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       match
);

    always_comb begin
        code  = GLYPH_INVALID;
        match = 1'b1;
        case (pattern)
            GLYPH_0:     code = 4'h0;
            GLYPH_1:     code = 4'h1;
            GLYPH_2:     code = 4'h2;
            GLYPH_3:     code = 4'h3;
            GLYPH_4:     code = 4'h4;
            GLYPH_5:     code = 4'h5;
            GLYPH_6:     code = 4'h6;
            GLYPH_7:     code = 4'h7;
            GLYPH_8:     code = 4'h8;
            GLYPH_9:     code = 4'h9;
            GLYPH_WATER: code = 4'hB;
            GLYPH_DASH:  code = 4'hC;
            GLYPH_ERROR: code = 4'hD;
            default: begin
                code  = GLYPH_INVALID;
                match = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/display_scan_capture.sv
// Listens to a multiplexed 7-segment display bus, waits for each scanned
// digit to settle and rebuilds a four-digit register image of what is shown.
module display_scan_capture
    import display_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES      = 4,
    parameter int TIMEOUT_CYCLES     = 65535,
    parameter bit SEGMENT_ACTIVE_LOW = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] display_n,
    input  logic [6:0] segments,
    input  logic       clear_errors,
    output logic [3:0] digit_3,
    output logic [3:0] digit_2,
    output logic [3:0] digit_1,
    output logic [3:0] digit_0,
    output logic [3:0] digit_valid,
    output logic       frame_done,
    output logic       scan_error,
    output logic       glyph_error,
    output logic       scan_stalled
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    // Synchronisers come out of reset showing an idle bus: no digit enabled,
    // no segment lit.
    localparam logic [6:0]  SEG_IDLE   = SEGMENT_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [10:0] SYNC_RESET = {4'hF, SEG_IDLE};

    logic [10:0]   sync_1;
    logic [10:0]   sync_2;
    logic [10:0]   sample_prev;
    logic [SW-1:0] settle_cnt;
    logic [TW-1:0] timeout_cnt;
    scan_state_t   state;
    logic [3:0]    seen_mask;
    logic [3:0]    digit_q [4];

    logic [3:0]    enables_s;
    logic [6:0]    segments_s;
    logic          changed;
    logic [SW-1:0] stable_cnt;
    logic          settled;
    enable_class_t en_class;
    logic [1:0]    sel;
    logic [6:0]    pattern;
    logic [3:0]    code;
    logic          match;
    logic          capture;
    logic          multi_hit;
    logic [3:0]    cap_mask;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= SYNC_RESET;
            sync_2 <= SYNC_RESET;
        end else begin
            sync_1 <= {display_n, segments};
            sync_2 <= sync_1;
        end
    end

    assign enables_s  = sync_2[10:7];
    assign segments_s = sync_2[6:0];
    assign changed    = (sync_2 != sample_prev);

    // Number of consecutive identical samples including the current one.
    assign stable_cnt = changed                    ? SW'(1) :
                        (settle_cnt == SETTLE_MAX) ? SETTLE_MAX :
                                                     settle_cnt + SW'(1);
    assign settled    = (stable_cnt == SETTLE_MAX);

    assign en_class = classify_enables(enables_s);
    assign sel      = active_index(enables_s);
    assign pattern  = SEGMENT_ACTIVE_LOW ? ~segments_s : segments_s;

    segment_glyph_decoder u_decoder (
        .pattern (pattern),
        .code    (code),
        .match   (match)
    );

    // HOLD blocks recapture of an unchanged digit; a change always re-arms.
    assign capture   = (en_class == EN_SINGLE) && settled
                       && (changed || (state != HOLD));
    // Multi-enable errors fire once, when the pattern first becomes settled,
    // so a clear is not immediately overridden while the pattern persists.
    assign multi_hit = (en_class == EN_MULTI) && settled
                       && (changed || (settle_cnt != SETTLE_MAX));
    assign cap_mask  = capture ? (4'b0001 << sel) : 4'b0000;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sample_prev <= SYNC_RESET;
            settle_cnt  <= '0;
            timeout_cnt <= '0;
            state       <= IDLE;
            seen_mask   <= 4'b0000;
            digit_valid <= 4'b0000;
            frame_done  <= 1'b0;
            scan_error  <= 1'b0;
            glyph_error <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= 4'h0;
            end
        end else begin
            sample_prev <= sync_2;
            settle_cnt  <= stable_cnt;

            case (en_class)
                EN_NONE:  state <= IDLE;
                EN_MULTI: state <= MULTI;
                default: begin
                    if (capture) begin
                        state <= HOLD;
                    end else if ((state == HOLD) && !changed) begin
                        state <= HOLD;
                    end else begin
                        state <= SETTLING;
                    end
                end
            endcase

            if (capture) begin
                digit_q[sel] <= match ? code : GLYPH_INVALID;
            end
            digit_valid <= digit_valid | cap_mask;

            // A completed frame reports once and restarts the mask, keeping
            // any capture that lands in the same cycle.
            if (seen_mask == 4'hF) begin
                frame_done <= 1'b1;
                seen_mask  <= cap_mask;
            end else begin
                frame_done <= 1'b0;
                seen_mask  <= seen_mask | cap_mask;
            end

            if (capture) begin
                timeout_cnt <= '0;
            end else if (timeout_cnt != TIMEOUT_MAX) begin
                timeout_cnt <= timeout_cnt + TW'(1);
            end

            if (multi_hit) begin
                scan_error <= 1'b1;
            end else if (clear_errors) begin
                scan_error <= 1'b0;
            end

            if (capture && !match) begin
                glyph_error <= 1'b1;
            end else if (clear_errors) begin
                glyph_error <= 1'b0;
            end
        end
    end

    assign digit_0      = digit_q[0];
    assign digit_1      = digit_q[1];
    assign digit_2      = digit_q[2];
    assign digit_3      = digit_q[3];
    assign scan_stalled = (timeout_cnt == TIMEOUT_MAX);

endmodule
